i2c_slave_responder: RTL and testbench
======================================

# i2c_slave_responder

Synthesizable single-address I2C slave endpoint attached to one open-drain SCL/SDA bus pair of the multi-bus I2C master controller. It decodes START, repeated START and STOP conditions, matches a configurable 7-bit address, and either absorbs master-written bytes into an RX FIFO or supplies master-read bytes from a TX FIFO. ACK and NACK are generated per the I2C protocol. A simple push/pop host port lets system logic preload transmit data and drain received data.

## Interface
- `DATA_WIDTH`, default 8: byte width; only 8 is legal.
- `FIFO_DEPTH`, default 16: entries in each of the RX and TX FIFOs; must be a power of 2.
- `TRANSFER_DEBUG_MODE`, default 0: simulation-only transfer print; no effect on logic.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1: system clock, at least 40× SCL frequency.
- `rst_i`  in  1: synchronous active-high reset.
- `scl_i`  in  1: bus clock, asynchronous; the slave never stretches it.
- `sda_i`  in  1: bus data, asynchronous.
- `sda_o`  out  1: open-drain data drive; 0 pulls low, 1 releases.
- `slave_addr`  in  7: device address; sampled at each address-byte compare.
- `tx_data`  in  8: byte to enqueue for master reads.
- `tx_push`  in  1: enqueue `tx_data`; ignored when the TX FIFO is full.
- `rx_data`  out  8: head of the RX FIFO.
- `rx_valid`  out  1: RX FIFO is not empty.
- `rx_pop`  in  1: dequeue the RX FIFO head.
- `tx_full`, `rx_full`  out  1 each: FIFO full flags.
- `most_recent_xfer`  out  8: last byte received or transmitted on the bus.
- `start_det`, `stop_det`  out  1 each: 1-cycle pulses on START (including repeated START) and on STOP.

## Operation
- Input conditioning: `scl_i` and `sda_i` each pass through a 2-flop synchronizer, then a 1-cycle-delayed copy for edge detection.
- Bus conditions, evaluated on the synchronized signals:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are honoured in every state.
  - START always enters ADDR with the bit counter cleared.
  - STOP always enters IDLE and releases `sda_o`.
- FSM states: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE.
  - ADDR: shift 8 bits, MSB first, on SCL rising edges. After the 8th bit:
    - If byte[7:1] equals `slave_addr`, enter ADDR_ACK.
    - Otherwise enter IGNORE, with SDA released until the next START or STOP.
  - ADDR_ACK: on the next SCL falling edge, drive `sda_o` low. On the following falling edge:
    - If R/W (byte[0]) is 0, release SDA and enter RX.
    - If R/W is 1, enter TX and drive bit 7 of the TX byte.
  - RX: shift 8 bits on rising edges. After the 8th bit, enter RX_ACK.
    - If the RX FIFO is not full: push the byte, update `most_recent_xfer`, and ACK (drive low from the next falling edge to the one after).
    - If the RX FIFO is full: drop the byte and NACK (keep SDA released).
    - Then return to RX.
  - TX: the TX byte is the TX FIFO head, popped when it is loaded; if the FIFO is empty the byte is 0xFF.
    - Present each bit on an SCL falling edge, MSB first.
    - After the 8th bit's hold, release SDA on the next falling edge and enter TX_ACK.
    - Update `most_recent_xfer` with the transmitted byte.
  - TX_ACK: sample SDA on the SCL rising edge.
    - ACK (0): load the next byte and, on the falling edge, drive its bit 7 and enter TX.
    - NACK (1): enter IGNORE.
- FIFOs:
  - Push and pop in the same cycle are both honoured.
  - A pop on empty and a push on full are no-ops.
  - Count width is log2(FIFO_DEPTH)+1.

## Timing
- Reset values:
  - `sda_o`=1, state=IDLE.
  - Both FIFOs empty, so `rx_valid`=0, `rx_full`=0, `tx_full`=0.
  - `rx_data`=0, `most_recent_xfer`=0, `start_det`=0, `stop_det`=0.
- Reset mid-transfer releases SDA within 1 cycle and discards FIFO contents.
- Bus-event latency: 3 `clk_i` cycles from an `scl_i`/`sda_i` edge to the FSM reaction. `sda_o` changes only after a detected SCL fall, so data is always stable while SCL is high.
- `rx_valid` asserts the cycle after the push. `rx_data` is valid combinationally from the FIFO head.
- `tx_push` takes effect on the next clock edge. A byte pushed before the TX load edge is transmitted.
- If START and an SCL edge are detected in the same cycle, START wins.

## Test plan
- Set `slave_addr`=0x12. Master sends START, 0x24, bytes 0x00..0x07, STOP → address ACK and 8 data ACKs; RX FIFO pops 0x00..0x07; `start_det` and `stop_det` each pulse once.
- Preload TX with 0x08..0x0F. Master sends START, 0x25, reads 7 bytes with ACK and the 8th with NACK, then STOP → master receives 0x08..0x0F; SDA is released after the NACK.
- Repeat 8 times: START, 0x24, write byte i, repeated START, 0x25, read 1 byte with NACK, STOP (i=0..7) → RX holds 0..7; TX bytes 0x08..0x0F are delivered in order; one `start_det` pulse per START.
- Master sends START, 0x26 → NACK (SDA high on the 9th clock); following bytes are ignored until STOP; RX FIFO is unchanged.
- With the RX FIFO full (16 entries), write 1 byte → data byte NACKed; `rx_full` stays 1; FIFO contents are unchanged.
- Assert `rst_i` for 1 cycle while driving an ACK low → `sda_o`=1 the next cycle; state IDLE; FIFOs empty.

Source files
------------

// File: rtl/i2c_slave_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | i2c_slave_responder : single-address I2C slave with RX/TX byte FIFOs        |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module i2c_slave_responder #(
  parameter int DATA_WIDTH          = 8,
  parameter int FIFO_DEPTH          = 16,
  parameter int TRANSFER_DEBUG_MODE = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  input  logic [6:0]            slave_addr,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_push,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_pop,
  output logic                  tx_full,
  output logic                  rx_full,
  output logic [DATA_WIDTH-1:0] most_recent_xfer,
  output logic                  start_det,
  output logic                  stop_det
);

  localparam int          c_PTR_W    = $clog2(FIFO_DEPTH);
  localparam int          c_CNT_W    = c_PTR_W + 1;
  localparam logic [3:0]  c_LAST_BIT = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]  c_ALL_BITS = 4'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_IGNORE
  } state_t;

  logic r_scl_s1, r_scl_s2, r_scl_d, r_sda_s1, r_sda_s2, r_sda_d;
  state_t r_state;
  logic [3:0] r_bitcnt;
  logic [DATA_WIDTH-2:0] r_shift;
  logic [DATA_WIDTH-1:0] r_txsh, r_txbyte, r_mrx, r_rx_wdata;
  logic r_rw, r_phase, r_ack, r_sda, r_rx_wr, r_start_det, r_stop_det;
  logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
  logic [c_CNT_W-1:0] r_rx_cnt, r_tx_cnt;

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_tx_load;
  logic w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_rx_full, w_tx_full;
  logic [DATA_WIDTH-1:0] w_tx_byte, w_rx_byte;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
      {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
    end else begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_i, r_scl_s1, r_scl_s2};
      {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_i, r_sda_s1, r_sda_s2};
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_rx_byte  = {r_shift, r_sda_s2};
  assign w_rx_full  = (r_rx_cnt == c_CNT_W'(FIFO_DEPTH));
  assign w_tx_full  = (r_tx_cnt == c_CNT_W'(FIFO_DEPTH));
  assign w_tx_byte  = (r_tx_cnt != '0) ? r_tx_mem[r_tx_rp] : '1;

  // TX byte is fetched (and the FIFO popped) on the fall that starts its bit 7.
  assign w_tx_load = !w_start && !w_stop && w_scl_fall && r_phase &&
                     ((r_state == S_ADDR_ACK && r_rw) || r_state == S_TX_ACK);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;   r_bitcnt <= '0;  r_shift <= '0;  r_txsh <= '0;
      r_txbyte <= '0;      r_mrx <= '0;     r_rx_wdata <= '0;
      r_rw <= 1'b0;        r_phase <= 1'b0; r_ack <= 1'b0;  r_sda <= 1'b1;
      r_rx_wr <= 1'b0;     r_start_det <= 1'b0; r_stop_det <= 1'b0;
    end else begin
      r_rx_wr     <= 1'b0;
      r_start_det <= w_start;
      r_stop_det  <= w_stop;
      if (w_start) begin
        r_state <= S_ADDR; r_bitcnt <= '0; r_phase <= 1'b0; r_sda <= 1'b1;
      end else if (w_stop) begin
        r_state <= S_IDLE; r_sda <= 1'b1;
      end else begin
        case (r_state)
          S_ADDR, S_RX: if (w_scl_rise) begin
            r_shift <= w_rx_byte[DATA_WIDTH-2:0];
            if (r_bitcnt == c_LAST_BIT) begin
              r_bitcnt <= '0;
              r_phase  <= 1'b0;
              if (r_state == S_ADDR) begin
                r_rw    <= r_sda_s2;
                r_state <= (r_shift == slave_addr) ? S_ADDR_ACK : S_IGNORE;
              end else begin
                r_state <= S_RX_ACK;
                r_ack   <= !w_rx_full;
                if (!w_rx_full) begin
                  r_rx_wr    <= 1'b1;
                  r_rx_wdata <= w_rx_byte;
                  r_mrx      <= w_rx_byte;
                end
              end
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
          S_ADDR_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda <= 1'b0; r_phase <= 1'b1;
            end else if (!r_rw) begin
              r_sda <= 1'b1; r_state <= S_RX;
            end else begin
              r_sda <= w_tx_byte[DATA_WIDTH-1];
              r_txsh <= {w_tx_byte[DATA_WIDTH-2:0], 1'b1};
              r_txbyte <= w_tx_byte; r_bitcnt <= 4'd1; r_state <= S_TX;
            end
          end
          S_RX_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda <= !r_ack; r_phase <= 1'b1;
            end else begin
              r_sda <= 1'b1; r_state <= S_RX;
            end
          end
          S_TX: if (w_scl_fall) begin
            if (r_bitcnt == c_ALL_BITS) begin
              r_sda <= 1'b1; r_mrx <= r_txbyte; r_phase <= 1'b0; r_state <= S_TX_ACK;
            end else begin
              r_sda <= r_txsh[DATA_WIDTH-1];
              r_txsh <= {r_txsh[DATA_WIDTH-2:0], 1'b1};
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
          S_TX_ACK: if (w_scl_rise) begin
            if (r_sda_s2) r_state <= S_IGNORE;
            else          r_phase <= 1'b1;
          end else if (w_tx_load) begin
            r_sda <= w_tx_byte[DATA_WIDTH-1];
            r_txsh <= {w_tx_byte[DATA_WIDTH-2:0], 1'b1};
            r_txbyte <= w_tx_byte; r_bitcnt <= 4'd1; r_state <= S_TX;
          end
          default: r_sda <= 1'b1;
        endcase
      end
    end
  end

  assign w_rx_push = r_rx_wr && !w_rx_full;
  assign w_rx_pop  = rx_pop && (r_rx_cnt != '0);
  assign w_tx_push = tx_push && !w_tx_full;
  assign w_tx_pop  = w_tx_load && (r_tx_cnt != '0);

  always_ff @(posedge clk_i) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_wdata;
    if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
    end
  end

  if (TRANSFER_DEBUG_MODE != 0) begin : g_xfer_debug
  end

  assign sda_o            = r_sda;
  assign rx_valid         = (r_rx_cnt != '0);
  assign rx_data          = rx_valid ? r_rx_mem[r_rx_rp] : '0;
  assign rx_full          = w_rx_full;
  assign tx_full          = w_tx_full;
  assign most_recent_xfer = r_mrx;
  assign start_det        = r_start_det;
  assign stop_det         = r_stop_det;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_i2c_slave_responder : bus-master driven bench with queue reference model |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_i2c_slave_responder;
  localparam int          Q    = 100;
  localparam logic [6:0]  SADR = 7'h12;

  logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic dut_sda, w_bus_sda, tx_push = 1'b0, rx_pop = 1'b0;
  logic [7:0] tx_data = '0, rx_data, mrx;
  logic rx_valid, tx_full, rx_full, start_det, stop_det;
  int n_assert = 0, n_fail = 0, n_start = 0, n_stop = 0;
  logic [7:0] model_rx[$], model_tx[$];

  assign w_bus_sda = sda_m & dut_sda;

  i2c_slave_responder #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .TRANSFER_DEBUG_MODE(0)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl_m), .sda_i(w_bus_sda), .sda_o(dut_sda),
    .slave_addr(SADR), .tx_data(tx_data), .tx_push(tx_push), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_pop(rx_pop), .tx_full(tx_full), .rx_full(rx_full),
    .most_recent_xfer(mrx), .start_det(start_det), .stop_det(stop_det));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_det) n_start++;
    if (stop_det)  n_stop++;
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus master primitives; data only ever changes while SCL is low.
  task automatic bus_start(); sda_m = 1; #Q; scl_m = 1; #Q; sda_m = 0; #Q; scl_m = 0; #Q; endtask
  task automatic bus_stop();  sda_m = 0; #Q; scl_m = 1; #Q; sda_m = 1; #Q; endtask
  task automatic wbit(input logic b); sda_m = b; #Q; scl_m = 1; #(2*Q); scl_m = 0; #Q; endtask
  task automatic rbit(output logic b);
    sda_m = 1; #Q; scl_m = 1; #Q; b = w_bus_sda; #Q; scl_m = 0; #Q;
  endtask
  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask
  task automatic rbyte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(nack);
  endtask

  // Reference model: an addressed write byte is ACKed iff the RX queue has room.
  task automatic m_addr(input string tag, input logic [6:0] a, input logic rw, output logic matched);
    logic ack;
    wbyte({a, rw}, ack);
    matched = (a == SADR);
    chk(tag, ack, matched ? 0 : 1);
  endtask
  task automatic m_write(input string tag, input logic [7:0] d, input logic addressed);
    logic ack, exp;
    wbyte(d, ack);
    exp = 1'b1;
    if (addressed && model_rx.size() < 16) begin exp = 1'b0; model_rx.push_back(d); end
    chk(tag, ack, exp);
  endtask
  task automatic m_read(input string tag, input logic nack);
    logic [7:0] d, exp;
    rbyte(nack, d);
    exp = (model_tx.size() > 0) ? model_tx.pop_front() : 8'hFF;
    chk(tag, d, exp);
  endtask
  task automatic push_tx(input logic [7:0] d);
    @(negedge clk); tx_data = d; tx_push = 1;
    @(negedge clk); tx_push = 0;
    if (model_tx.size() < 16) model_tx.push_back(d);
  endtask
  task automatic drain_rx(input string tag);
    @(negedge clk);
    while (model_rx.size() > 0) begin
      chk({tag, "_valid"}, rx_valid, 1);
      chk({tag, "_data"}, rx_data, model_rx.pop_front());
      rx_pop = 1; @(negedge clk); rx_pop = 0;
    end
    chk({tag, "_empty"}, rx_valid, 0);
  endtask

  initial begin
    logic m;
    logic [7:0] abyte;
    int s0, p0, len;
    logic [6:0] ra;
    logic rw;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sda", dut_sda, 1);     chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_full", rx_full, 0); chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_data", rx_data, 0); chk("rst_mrx", mrx, 0);
    chk("rst_start", start_det, 0); chk("rst_stop", stop_det, 0);
    rst = 0;
    repeat (5) @(negedge clk);

    // Eight-byte write
    s0 = n_start; p0 = n_stop;
    bus_start(); m_addr("t1_addr", SADR, 0, m);
    for (int i = 0; i < 8; i++) m_write("t1_wr", 8'(i), m);
    bus_stop(); #Q;
    chk("t1_starts", n_start - s0, 1); chk("t1_stops", n_stop - p0, 1);
    chk("t1_mrx", mrx, 8'h07);
    drain_rx("t1_rx");

    // Eight-byte read, last byte NACKed
    for (int i = 8; i < 16; i++) push_tx(8'(i));
    bus_start(); m_addr("t2_addr", SADR, 1, m);
    for (int i = 0; i < 8; i++) m_read("t2_rd", i == 7);
    chk("t2_release", dut_sda, 1);
    bus_stop(); #Q;
    chk("t2_mrx", mrx, 8'h0F);

    // Write / repeated START / read, eight rounds
    for (int i = 8; i < 16; i++) push_tx(8'(i));
    for (int i = 0; i < 8; i++) begin
      s0 = n_start;
      bus_start(); m_addr("t3_waddr", SADR, 0, m); m_write("t3_wr", 8'(i), 1);
      bus_start(); m_addr("t3_raddr", SADR, 1, m); m_read("t3_rd", 1);
      bus_stop(); #Q;
      chk("t3_starts", n_start - s0, 2);
    end
    drain_rx("t3_rx");

    // TX FIFO full; overflow push dropped, then empty FIFO reads 0xFF
    for (int i = 0; i < 16; i++) push_tx(8'hA0 + 8'(i));
    @(negedge clk); chk("t4_tx_full", tx_full, 1);
    push_tx(8'hEE);
    bus_start(); m_addr("t4_addr", SADR, 1, m);
    for (int i = 0; i < 17; i++) m_read("t4_rd", i == 16);
    bus_stop(); #Q;
    chk("t4_tx_notfull", tx_full, 0);

    // Address mismatch
    bus_start(); m_addr("t5_addr_nack", 7'h13, 0, m);
    m_write("t5_ignored", 8'h55, 0);
    bus_stop(); #Q;
    chk("t5_rx_empty", rx_valid, 0);

    // RX FIFO full: 17th byte NACKed and dropped
    bus_start(); m_addr("t6_addr", SADR, 0, m);
    for (int i = 0; i < 16; i++) m_write("t6_wr", 8'h30 + 8'(i), 1);
    bus_stop(); #Q;
    chk("t6_rx_full", rx_full, 1);
    bus_start(); m_addr("t6_addr2", SADR, 0, m);
    m_write("t6_over_nack", 8'h99, 1);
    bus_stop(); #Q;
    chk("t6_still_full", rx_full, 1);
    drain_rx("t6_rx");

    // Randomized transactions against the queue model
    for (int k = 0; k < 5; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SADR;
      if (k == 0) ra = SADR ^ 7'h40;
      rw = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 3);
      if (rw && ra == SADR)
        for (int j = 0; j < int'($urandom_range(0, 3)); j++) push_tx(8'($urandom));
      bus_start(); m_addr("rnd_addr", ra, rw, m);
      if (!m)      m_write("rnd_ignored", 8'($urandom), 0);
      else if (rw) for (int j = 0; j < len; j++) m_read("rnd_rd", j == len - 1);
      else         for (int j = 0; j < len; j++) m_write("rnd_wr", 8'($urandom), 1);
      bus_stop(); #Q;
    end
    drain_rx("rnd_rx");

    // Reset while the address ACK is driven low
    push_tx(8'h5A); push_tx(8'hA5);
    bus_start(); m_addr("t7_waddr", SADR, 0, m); m_write("t7_wr", 8'h77, 1);
    bus_stop(); #Q;
    bus_start();
    abyte = {SADR, 1'b0};
    for (int i = 7; i >= 0; i--) wbit(abyte[i]);
    sda_m = 1; #Q;
    chk("t7_ack_low", dut_sda, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    chk("t7_rst_release", dut_sda, 1);
    rst = 0;
    model_rx.delete(); model_tx.delete();
    @(negedge clk);
    chk("t7_rx_empty", rx_valid, 0); chk("t7_mrx", mrx, 0);
    bus_stop(); #Q;
    bus_start(); m_addr("t7_raddr", SADR, 1, m); m_read("t7_tx_empty", 1);
    bus_stop(); #Q;
    drain_rx("t7_rx");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
